// File: rtl/char_move_controller_pkg.sv
// rtl/char_move_controller_pkg.sv - shared types and constants for the sprite movement controller
package char_move_pkg;

    // Facing direction, encoded the way the frame drawer indexes its sprite sheet
    typedef enum logic [1:0] {
        DOWN  = 2'd0,
        UP    = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    // Movement sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        DECIDE = 2'd2,
        MOVE   = 2'd3
    } state_t;

    // USB HID keycodes: WASD walks, IJKL runs
    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_S = 8'h16;
    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_D = 8'h07;
    localparam logic [7:0] KEY_I = 8'h0C;
    localparam logic [7:0] KEY_K = 8'h0E;
    localparam logic [7:0] KEY_J = 8'h0D;
    localparam logic [7:0] KEY_L = 8'h0F;

    // Game states
    localparam logic [3:0] GS_TITLE     = 4'd0;
    localparam logic [3:0] GS_INTRO     = 4'd1;
    localparam logic [3:0] GS_OVERWORLD = 4'd2;

endpackage

// File: rtl/char_move_controller_if.sv
// rtl/char_move_controller_if.sv - keyboard/collision/frame-drawer signal bundle for the movement controller
interface char_move_controller_if;
    logic       frame_tick;
    logic [7:0] keycode;
    logic [3:0] state_num;
    logic       blocked;
    logic [5:0] tgt_tx;
    logic [4:0] tgt_ty;
    logic [9:0] charxcurrpos;
    logic [9:0] charycurrpos;
    logic [1:0] direction;
    logic [1:0] charMoveFrame;
    logic       charIsMoving;
    logic       charIsRunning;
    logic       atTile;

    // Environment side: supplies frame/key/collision, consumes sprite state
    modport master (
        output frame_tick, keycode, state_num, blocked,
        input  tgt_tx, tgt_ty, charxcurrpos, charycurrpos, direction,
               charMoveFrame, charIsMoving, charIsRunning, atTile
    );

    // Controller side
    modport slave (
        input  frame_tick, keycode, state_num, blocked,
        output tgt_tx, tgt_ty, charxcurrpos, charycurrpos, direction,
               charMoveFrame, charIsMoving, charIsRunning, atTile
    );
endinterface

// File: rtl/char_move_controller_key_decode.sv
// rtl/char_move_controller_key_decode.sv - combinational keycode to direction/run decoder
module char_key_decode
    import char_move_pkg::*;
#(
    parameter bit RUN_EN = 1'b0
) (
    input  logic [7:0] i_keycode,
    output logic       o_key_valid,
    output dir_t       o_key_dir,
    output logic       o_key_run
);

    logic w_run;

    // Map the eight movement keys; anything else reads as no key
    always_comb begin
        o_key_valid = 1'b1;
        o_key_dir   = DOWN;
        w_run       = 1'b0;
        case (i_keycode)
            KEY_W: o_key_dir = UP;
            KEY_S: o_key_dir = DOWN;
            KEY_A: o_key_dir = LEFT;
            KEY_D: o_key_dir = RIGHT;
            KEY_I: begin o_key_dir = UP;    w_run = 1'b1; end
            KEY_K: begin o_key_dir = DOWN;  w_run = 1'b1; end
            KEY_J: begin o_key_dir = LEFT;  w_run = 1'b1; end
            KEY_L: begin o_key_dir = RIGHT; w_run = 1'b1; end
            default: o_key_valid = 1'b0;
        endcase
        // With running disabled the run keys collapse onto their walk twins
        o_key_run = RUN_EN & w_run;
    end

endmodule

// File: rtl/char_move_controller.sv
// rtl/char_move_controller.sv - per-frame tile stepping sequencer for the player sprite; CHAR_RUN_EN enables run speed
module char_move_controller
    import char_move_pkg::*;
#(
    parameter int         TILE      = 16,
    parameter int         START_X   = 160,
    parameter int         START_Y   = 112,
    parameter int         MAX_X     = 624,
    parameter int         MAX_Y     = 464,
    parameter logic [3:0] OVERWORLD = GS_OVERWORLD
) (
    input  logic                 Clk,
    input  logic                 Reset,
    char_move_controller_if.slave io_mv
);

`ifdef CHAR_RUN_EN
    localparam bit RUN_EN = 1'b1;
`else
    localparam bit RUN_EN = 1'b0;
`endif

    localparam int         SH   = $clog2(TILE);
    localparam int         CW   = SH + 1;
    localparam logic [9:0] SX   = 10'(START_X);
    localparam logic [9:0] SY   = 10'(START_Y);
    localparam logic [9:0] MAXX = 10'(MAX_X);
    localparam logic [9:0] MAXY = 10'(MAX_Y);

    state_t          r_state;
    dir_t            r_dir;
    logic [9:0]      r_x;
    logic [9:0]      r_y;
    logic [CW-1:0]   r_cnt;
    logic            r_run;
    logic            r_oob;
    logic [5:0]      r_tx;
    logic [4:0]      r_ty;
    logic [1:0]      r_frame;
    logic            r_moving;
    logic            r_running;
    logic            r_attile;

    logic            w_key_valid;
    dir_t            w_key_dir;
    logic            w_key_run;
    logic            w_oob;
    logic [5:0]      w_tx;
    logic [4:0]      w_ty;
    logic [CW-1:0]   w_step;
    logic [CW-1:0]   w_cnt_nxt;

    char_key_decode #(
        .RUN_EN      (RUN_EN)
    ) u_key_decode (
        .i_keycode   (io_mv.keycode),
        .o_key_valid (w_key_valid),
        .o_key_dir   (w_key_dir),
        .o_key_run   (w_key_run)
    );

    // Neighbour tile in the key direction; an edge step is flagged rather than computed so nothing wraps
    always_comb begin
        w_oob = 1'b0;
        w_tx  = 6'(r_x >> SH);
        w_ty  = 5'(r_y >> SH);
        case (w_key_dir)
            LEFT:  if (r_x == 10'd0) w_oob = 1'b1; else w_tx = w_tx - 6'd1;
            RIGHT: if (r_x >= MAXX)  w_oob = 1'b1; else w_tx = w_tx + 6'd1;
            UP:    if (r_y == 10'd0) w_oob = 1'b1; else w_ty = w_ty - 5'd1;
            default: if (r_y >= MAXY) w_oob = 1'b1; else w_ty = w_ty + 5'd1;
        endcase
    end

    assign w_step    = r_run ? CW'(2) : CW'(1);
    assign w_cnt_nxt = r_cnt + w_step;

    // Movement FSM with all drawer-facing outputs registered alongside the state
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state   <= IDLE;
            r_dir     <= DOWN;
            r_x       <= SX;
            r_y       <= SY;
            r_cnt     <= '0;
            r_run     <= 1'b0;
            r_oob     <= 1'b0;
            r_tx      <= '0;
            r_ty      <= '0;
            r_frame   <= 2'd0;
            r_moving  <= 1'b0;
            r_running <= 1'b0;
            r_attile  <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (io_mv.frame_tick && io_mv.state_num == OVERWORLD && w_key_valid) begin
                        if (w_key_dir != r_dir) begin
                            r_dir <= w_key_dir;
                        end else begin
                            r_run     <= w_key_run;
                            r_oob     <= w_oob;
                            r_tx      <= w_tx;
                            r_ty      <= w_ty;
                            r_moving  <= 1'b1;
                            r_running <= w_key_run;
                            r_attile  <= 1'b0;
                            r_state   <= LOOKUP;
                        end
                    end
                end
                LOOKUP: r_state <= DECIDE;
                DECIDE: begin
                    if (r_oob || io_mv.blocked) begin
                        r_moving  <= 1'b0;
                        r_running <= 1'b0;
                        r_attile  <= 1'b1;
                        r_state   <= IDLE;
                    end else begin
                        r_cnt   <= '0;
                        r_frame <= 2'd0;
                        r_state <= MOVE;
                    end
                end
                MOVE: begin
                    if (io_mv.frame_tick) begin
                        case (r_dir)
                            LEFT:    r_x <= r_x - 10'(w_step);
                            RIGHT:   r_x <= r_x + 10'(w_step);
                            UP:      r_y <= r_y - 10'(w_step);
                            default: r_y <= r_y + 10'(w_step);
                        endcase
                        r_cnt <= w_cnt_nxt;
                        if (w_cnt_nxt >= CW'(TILE)) begin
                            r_frame   <= 2'd0;
                            r_moving  <= 1'b0;
                            r_running <= 1'b0;
                            r_attile  <= 1'b1;
                            r_state   <= IDLE;
                        end else begin
                            r_frame <= w_cnt_nxt[3:2];
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign io_mv.tgt_tx        = r_tx;
    assign io_mv.tgt_ty        = r_ty;
    assign io_mv.charxcurrpos  = r_x;
    assign io_mv.charycurrpos  = r_y;
    assign io_mv.direction     = r_dir;
    assign io_mv.charMoveFrame = r_frame;
    assign io_mv.charIsMoving  = r_moving;
    assign io_mv.charIsRunning = r_running;
    assign io_mv.atTile        = r_attile;

endmodule

// File: doc/char_move_controller.md
# char_move_controller

Sequences the player sprite's overworld movement for the frame drawer. Once per video frame it samples the keyboard, checks the target tile against a 1-cycle tile-collision lookup, then steps the sprite one tile at walk or run speed. It drives the position, facing, animation and motion flags that the frame drawer consumes (`charxcurrpos`, `charycurrpos`, `direction`, `charMoveFrame`, `charIsMoving`, `charIsRunning`, `atTile`).

## Interface

Parameters:
- `TILE`, 16: tile size in px; power of 2.
- `START_X`, 160: reset x position in px; multiple of `TILE`.
- `START_Y`, 112: reset y position in px; multiple of `TILE`.
- `MAX_X`, 624: largest legal x (640−TILE).
- `MAX_Y`, 464: largest legal y (480−TILE).
- `OVERWORLD`, 4'd2: `state_num` value in which movement is enabled.

Ports:
- `Clk` input 1: system clock; all logic on the rising edge.
- `Reset` input 1: asynchronous, active-low reset.
- `frame_tick` input 1: one-cycle pulse per video frame, generated at vertical-sync start.
- `keycode` input 8: current USB HID keycode; 0 means no key.
- `state_num` input 4: game state.
- `blocked` input 1: collision result for `tgt_tx`/`tgt_ty`; valid exactly 1 cycle after the address is presented.
- `tgt_tx` output 6: target tile x (px/TILE).
- `tgt_ty` output 5: target tile y.
- `charxcurrpos` output 10: sprite x in px.
- `charycurrpos` output 10: sprite y in px.
- `direction` output 2: facing; 0 down, 1 up, 2 left, 3 right.
- `charMoveFrame` output 2: walk-cycle frame.
- `charIsMoving` output 1: a tile step is in progress.
- `charIsRunning` output 1: the current step is at run speed.
- `atTile` output 1: idle and tile-aligned.

## Operation

- Key map:
  - Walk: W 0x1A up, S 0x16 down, A 0x04 left, D 0x07 right.
  - Run: I 0x0C up, K 0x0E down, J 0x0D left, L 0x0F right.
  - Any other code is treated as no key.
- FSM states: IDLE, LOOKUP, DECIDE, MOVE.
- IDLE:
  - Acts on `frame_tick` only if `state_num==OVERWORLD` and a movement key is valid.
  - Key direction differs from `direction`: update `direction`, stay in IDLE. This is a turn-only frame with no step.
  - Key direction equals `direction`: latch the run flag, drive `tgt_tx`/`tgt_ty` with the neighbour tile, go to LOOKUP.
- LOOKUP: one wait cycle, then go to DECIDE.
- DECIDE: sample `blocked`.
  - Treat the step as blocked if the target leaves 0..`MAX_X` / 0..`MAX_Y`, regardless of `blocked`.
  - Blocked: return to IDLE; position unchanged.
  - Else: clear the step counter, go to MOVE.
- MOVE:
  - On each `frame_tick`, advance position by 1 px (walk) or 2 px (run) in `direction`.
  - Add the same amount to the px counter.
  - When the counter reaches `TILE`, return to IDLE. The final position is exactly one tile from the start.
  - Key release, key change or a `state_num` change mid-step do not abort the step. The new key is evaluated at the next IDLE tick.
- `charMoveFrame`: equals `counter[3:2]` while in MOVE; 0 otherwise.
- `charIsMoving`: 1 in LOOKUP, DECIDE and MOVE.
- `charIsRunning`: the latched run flag while `charIsMoving`; 0 otherwise.
- `atTile`: 1 only in IDLE.
- Arithmetic: position stays unsigned 10-bit. Bounds checks are done before any addition or subtraction, so no wrap-around is possible.

## Timing

- Reset values:
  - Position = (`START_X`, `START_Y`), `direction`=0.
  - All flags 0, except `atTile`=1.
  - `charMoveFrame`=0, `tgt_tx`=`tgt_ty`=0, FSM in IDLE.
- Reset asserted mid-step: return to reset values immediately, with no completion of the step.
- IDLE tick to first pixel moved: the first pixel moves on the next `frame_tick` after DECIDE, provided DECIDE falls within the same frame.
- `frame_tick` during LOOKUP or DECIDE: ignored.
- Step duration: walk takes 16 ticks, run takes 8 ticks.
- All outputs are registered. `tgt_*` stay stable from IDLE exit through DECIDE.

## Configuration

- `CHAR_RUN_EN` defined: run keys produce 2 px/tick and assert `charIsRunning`.
- `CHAR_RUN_EN` undefined: run keys behave as the matching walk keys, and `charIsRunning` is tied to 0.

## Structure

- Package `char_move_pkg` holds:
  - `dir_t` enum (DOWN, UP, LEFT, RIGHT).
  - Keycode constants.
  - FSM state enum.
  - Game-state constants, including the OVERWORLD value.
- Sub-module `char_key_decode` (combinational): maps `keycode` to `key_valid`, `key_dir` and `key_run`.

## Test plan

- Reset, then hold D (0x07) with `blocked`=0 → `direction` becomes 3 on the first tick. The next IDLE tick starts the step; after 16 ticks `charxcurrpos`=176, `atTile`=1, and `charMoveFrame` has cycled 0,1,2,3.
- Facing right, hold L (0x0F) with `CHAR_RUN_EN` defined → `charxcurrpos` goes 160→176 in 8 ticks with `charIsRunning`=1. Without the macro the step takes 16 ticks and `charIsRunning`=0.
- Face up and hold W with `blocked`=1 → position stays unchanged, `charIsMoving` pulses for LOOKUP/DECIDE only, and `atTile` returns to 1.
- Place the sprite at x=0 facing left and hold A with `blocked`=0 → the step is refused and x stays 0.
- Release the key at tick 5 of a walk step → the step completes at 16 ticks.
- Assert `Reset` low at tick 8 of a step → position is immediately (160, 112) and `charIsMoving`=0.
- `state_num`≠2 with S held → no turn and no step.
